vec_fir_mac: RTL and testbench

Pipelined SIMD multiply-accumulate stage for the FIR datapath. It sits directly downstream of the vector register file and takes its two read-port vectors, one sample vector and one coefficient vector, each 16 signed 8-bit lanes. Each cycle it forms their lane-wise dot product and accumulates it across a multi-beat tap sequence. At the end of the sequence it emits the accumulator and a saturated, rescaled 8-bit result packed into a register-file write word.

---
 rtl/vec_fir_mac.sv | 149 ++++++++++++++
 tb/tb_vec_fir_mac.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_fir_mac.sv
// rtl/vec_fir_mac.sv - pipelined SIMD dot-product multiply-accumulate stage for the FIR datapath
//
// Three register stages: lane products, 4-lane partial sums, then dot-product
// accumulation with rescale/saturation into a register-file write word.
//
// Ports:
//   clk, rst               clock; asynchronous active-high reset
//   in_valid/in_ready      input beat handshake (in_ready = !stall)
//   in_first/in_last       beat starts / ends a sum
//   va, vb                 sample and coefficient vectors, [lanes][bits], signed lanes
//   out_valid/out_ready    result handshake
//   acc_out                full-precision accumulated sum
//   wd_out                 write word, lane 0 = saturated (acc >>> SHIFT), other lanes 0
//   sat_flag               lane 0 was clamped
module vec_fir_mac #(
  parameter int VECTORSPERREG = 16,
  parameter int DATAWIDTH     = 8,
  parameter int ACCWIDTH      = 32,
  parameter int SHIFT         = 7
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic                                     in_first,
  input  logic                                     in_last,
  input  logic [VECTORSPERREG-1:0][DATAWIDTH-1:0]  va,
  input  logic [VECTORSPERREG-1:0][DATAWIDTH-1:0]  vb,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [ACCWIDTH-1:0]                      acc_out,
  output logic [VECTORSPERREG-1:0][DATAWIDTH-1:0]  wd_out,
  output logic                                     sat_flag
);

  localparam int PW     = 2 * DATAWIDTH;
  localparam int SW     = PW + 2;
  localparam int GROUPS = VECTORSPERREG / 4;

  localparam logic signed [ACCWIDTH-1:0] SAT_MAX = ACCWIDTH'((1 << (DATAWIDTH - 1)) - 1);
  localparam logic signed [ACCWIDTH-1:0] SAT_MIN = -SAT_MAX - 1;

  logic stall;

  // The only backpressure is a held, untaken result; all stages freeze together.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Stage 1 registers: lane products plus tags
  logic                            s1_valid, s1_first, s1_last;
  logic [VECTORSPERREG-1:0][PW-1:0] prod_c, s1_prod;

  // Stage 2 registers: partial sums plus tags
  logic                        s2_valid, s2_first, s2_last;
  logic [GROUPS-1:0][SW-1:0]   part_c, s2_part;

  // Stage 3 state
  logic signed [ACCWIDTH-1:0]  acc, dot_c, acc_next, shifted;
  logic [DATAWIDTH-1:0]        lane_c;
  logic                        sat_c;
  logic [VECTORSPERREG-1:0][DATAWIDTH-1:0] wd_c;

  always_comb begin
    prod_c = '0;
    for (int i = 0; i < VECTORSPERREG; i++) begin
      prod_c[i] = PW'($signed(va[i])) * PW'($signed(vb[i]));
    end
  end

  always_comb begin
    part_c = '0;
    for (int g = 0; g < GROUPS; g++) begin
      for (int k = 0; k < 4; k++) begin
        part_c[g] = part_c[g] + SW'($signed(s1_prod[4*g+k]));
      end
    end
  end

  always_comb begin
    dot_c = '0;
    for (int g = 0; g < GROUPS; g++) begin
      dot_c = dot_c + ACCWIDTH'($signed(s2_part[g]));
    end
    // Wraps modulo 2^ACCWIDTH by construction.
    acc_next = (s2_first ? '0 : acc) + dot_c;
    shifted  = acc_next >>> SHIFT;

    sat_c  = 1'b0;
    lane_c = shifted[DATAWIDTH-1:0];
    if (shifted > SAT_MAX) begin
      lane_c = SAT_MAX[DATAWIDTH-1:0];
      sat_c  = 1'b1;
    end else if (shifted < SAT_MIN) begin
      lane_c = SAT_MIN[DATAWIDTH-1:0];
      sat_c  = 1'b1;
    end

    wd_c    = '0;
    wd_c[0] = lane_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_prod   <= '0;
      s2_valid  <= 1'b0;
      s2_first  <= 1'b0;
      s2_last   <= 1'b0;
      s2_part   <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      acc_out   <= '0;
      wd_out    <= '0;
      sat_flag  <= 1'b0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_first <= in_first;
      s1_last  <= in_last;
      if (in_valid) begin
        s1_prod <= prod_c;
      end

      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      if (s1_valid) begin
        s2_part <= part_c;
      end

      // Not stalled means either nothing is pending or it is being taken now,
      // so out_valid simply follows whether a sum completes on this edge.
      out_valid <= s2_valid && s2_last;

      if (s2_valid) begin
        if (s2_last) begin
          acc      <= '0;
          acc_out  <= acc_next;
          wd_out   <= wd_c;
          sat_flag <= sat_c;
        end else begin
          acc <= acc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_fir_mac.sv
// tb/tb_vec_fir_mac.sv - self-checking bench for vec_fir_mac
module tb_vec_fir_mac;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 in_first = 1'b0;
  logic                 in_last = 1'b0;
  logic [15:0][7:0]     va = '0;
  logic [15:0][7:0]     vb = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [31:0]          acc_out;
  logic [15:0][7:0]     wd_out;
  logic                 sat_flag;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int a;
    int b;
    int exp_acc;
    int exp_lane;
    bit exp_sat;
  } vec_t;

  typedef struct {
    int acc;
    int lane;
    bit sat;
  } res_t;

  vec_t tab[8];
  res_t q[$];

  always #5 clk = ~clk;

  vec_fir_mac #(
    .VECTORSPERREG(16),
    .DATAWIDTH(8),
    .ACCWIDTH(32),
    .SHIFT(7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_first(in_first),
    .in_last(in_last),
    .va(va),
    .vb(vb),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc_out(acc_out),
    .wd_out(wd_out),
    .sat_flag(sat_flag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_res(input string name, input int eacc, input int elane, input bit esat);
    logic [127:0] ewd;
    logic [7:0]   l8;
    l8  = 8'(elane);
    ewd = {120'b0, l8};
    chk({name, "_acc"}, $signed(acc_out), eacc);
    n_tests++;
    if (wd_out !== ewd) begin
      n_fail++;
      $display("FAIL %s_wd: got %h expected %h", name, wd_out, ewd);
    end
    chk({name, "_sat"}, sat_flag, esat);
  endtask

  task automatic set_beat(input int a, input int b, input bit f, input bit l);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    for (int i = 0; i < 16; i++) begin
      va[i] = 8'(a);
      vb[i] = 8'(b);
    end
  endtask

  function automatic int dot(input logic [15:0][7:0] a, input logic [15:0][7:0] b);
    int s;
    s = 0;
    for (int i = 0; i < 16; i++) s += int'($signed(a[i])) * int'($signed(b[i]));
    return s;
  endfunction

  // Rescale as a floor division by 2^7, then clamp to the signed 8-bit range.
  function automatic res_t ref_out(input int acc);
    res_t   r;
    longint qd;
    qd = longint'(acc) / 128;
    if (acc < 0 && (acc % 128) != 0) qd = qd - 1;
    r.acc  = acc;
    r.sat  = (qd > 127) || (qd < -128);
    r.lane = (qd > 127) ? 127 : (qd < -128) ? -128 : int'(qd);
    return r;
  endfunction

  initial begin
    bit   hold;
    bit   accepted;
    bit   take;
    int   macc;
    res_t r;

    tab[0] = '{a: 1,    b: 2,    exp_acc: 32,      exp_lane: 0,    exp_sat: 0};
    tab[1] = '{a: 127,  b: 127,  exp_acc: 258064,  exp_lane: 127,  exp_sat: 1};
    tab[2] = '{a: -128, b: 127,  exp_acc: -260096, exp_lane: -128, exp_sat: 1};
    tab[3] = '{a: 16,   b: 16,   exp_acc: 4096,    exp_lane: 32,   exp_sat: 0};
    tab[4] = '{a: -1,   b: 1,    exp_acc: -16,     exp_lane: -1,   exp_sat: 0};
    tab[5] = '{a: 0,    b: 5,    exp_acc: 0,       exp_lane: 0,    exp_sat: 0};
    tab[6] = '{a: 100,  b: -100, exp_acc: -160000, exp_lane: -128, exp_sat: 1};
    tab[7] = '{a: 8,    b: 8,    exp_acc: 1024,    exp_lane: 8,    exp_sat: 0};

    // Reset state
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk_res("rst", 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();

    // Single-beat table with latency and one-cycle output pulse
    for (int t = 0; t < 8; t++) begin
      set_beat(tab[t].a, tab[t].b, 1, 1);
      tick();
      in_valid = 1'b0;
      chk("lat_e0", out_valid, 0);
      tick();
      chk("lat_e1", out_valid, 0);
      tick();
      chk("lat_e2", out_valid, 1);
      chk_res($sformatf("tab%0d", t), tab[t].exp_acc, tab[t].exp_lane, tab[t].exp_sat);
      tick();
      chk("pulse_end", out_valid, 0);
    end

    // Three-beat sum
    set_beat(16, 16, 1, 0);
    tick();
    chk("tap_b0", out_valid, 0);
    set_beat(16, 16, 0, 0);
    tick();
    chk("tap_b1", out_valid, 0);
    set_beat(16, 16, 0, 1);
    tick();
    in_valid = 1'b0;
    chk("tap_b2", out_valid, 0);
    tick();
    chk("tap_b3", out_valid, 0);
    tick();
    chk("tap_valid", out_valid, 1);
    chk_res("tap3", 12288, 96, 0);
    tick();
    chk("tap_end", out_valid, 0);

    // Stall with two pending single-beat sums
    out_ready = 1'b0;
    set_beat(1, 2, 1, 1);
    tick();
    set_beat(2, 2, 1, 1);
    tick();
    in_valid = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_acc", $signed(acc_out), 32);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", in_ready, 1);
    tick();
    chk("second_valid", out_valid, 1);
    chk_res("second", 64, 0, 0);
    tick();
    chk("second_end", out_valid, 0);

    // Continuous last-every-beat stream
    for (int k = 0; k < 8; k++) begin
      set_beat((k % 2) ? 2 : 1, 2, 1, 1);
      tick();
      if (k >= 2) begin
        chk("stream_valid", out_valid, 1);
        chk("stream_in_ready", in_ready, 1);
        chk("stream_acc", $signed(acc_out), ((k - 2) % 2) ? 64 : 32);
      end
    end
    in_valid = 1'b0;
    tick();
    chk("stream_tail0", $signed(acc_out), 32);
    tick();
    chk("stream_tail1", $signed(acc_out), 64);
    tick();
    chk("stream_end", out_valid, 0);

    // Reset in the middle of a 3-beat sum
    set_beat(1, 1, 1, 0);
    tick();
    set_beat(1, 1, 0, 0);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk_res("midrst", 0, 0, 0);
    #1;
    rst = 1'b0;
    tick();
    set_beat(1, 1, 0, 1);
    tick();
    in_valid = 1'b0;
    chk("postrst_e0", out_valid, 0);
    tick();
    chk("postrst_e1", out_valid, 0);
    tick();
    chk("postrst_valid", out_valid, 1);
    chk_res("postrst", 16, 0, 0);
    tick();

    // Randomized traffic against the transaction-level model
    macc = 0;
    hold = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_first = ($urandom_range(0, 3) == 0);
        in_last  = ($urandom_range(0, 2) == 0);
        for (int i = 0; i < 16; i++) begin
          va[i] = 8'($urandom);
          vb[i] = 8'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      accepted = in_valid && in_ready;
      take     = out_valid && out_ready;
      hold     = in_valid && !in_ready;
      if (take) begin
        chk("rand_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          r = q.pop_front();
          chk_res("rand", r.acc, r.lane, r.sat);
        end
      end
      if (accepted) begin
        macc = (in_first ? 0 : macc) + dot(va, vb);
        if (in_last) begin
          q.push_back(ref_out(macc));
          macc = 0;
        end
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid) begin
        chk("drain_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          r = q.pop_front();
          chk_res("drain", r.acc, r.lane, r.sat);
        end
      end
      tick();
    end
    chk("drain_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
